// File: rtl/demux_rr_scheduler_if.sv
// Handshake and channel bundle between an upstream producer and the round-robin demux scheduler.
interface demux_rr_scheduler_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [7:0]        ch_en;
    logic [7:0]        ch_ready;
    logic [2:0]        sel;
    logic [7:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        drop_cnt;

    modport slave (
        input  in_valid, in_data, ch_en, ch_ready,
        output in_ready, sel, out_valid, out_data, drop_cnt
    );

    modport master (
        output in_valid, in_data, ch_en, ch_ready,
        input  in_ready, sel, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Holds one word and offers it to a round-robin-chosen enabled channel of a 1x8 demux;
// a word stalled for longer than TIMEOUT cycles is dropped and counted.
module demux_rr_scheduler #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_rr_scheduler_if.slave bus
);
    localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    state_e              r_state, w_state_nxt;
    logic [2:0]          r_ptr, w_ptr_nxt;
    logic [2:0]          r_sel, w_sel_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
    logic [7:0]          r_drop, w_drop_nxt;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_sel_ready;
    logic [2:0]          w_pick;
    logic [2:0]          w_idx;
    logic                w_found;

    assign w_in_ready  = (r_state == ST_IDLE) & (|bus.ch_en) & rst_n;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_sel_ready = bus.ch_ready[r_sel];

    // First enabled channel searching circularly upward from the pointer.
    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && bus.ch_en[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        w_wait_nxt  = r_wait;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_sel_nxt   = w_pick;
                    w_data_nxt  = bus.in_data;
                    w_wait_nxt  = '0;
                end
            end
            ST_SEND: begin
                // A ready channel wins over a timeout reached in the same cycle.
                if (w_sel_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_sel + 3'd1;
                end else if ((TIMEOUT != 0) && (r_wait == TIMEOUT_W)) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_sel + 3'd1;
                    if (r_drop != 8'hFF) begin
                        w_drop_nxt = r_drop + 8'd1;
                    end
                end else begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_data  <= '0;
            r_wait  <= '0;
            r_drop  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_data  <= w_data_nxt;
            r_wait  <= w_wait_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.sel       = r_sel;
    assign bus.out_valid = (r_state == ST_SEND) ? (8'd1 << r_sel) : 8'd0;
    assign bus.out_data  = r_data;
    assign bus.drop_cnt  = r_drop;
endmodule
